redmule_cfg_master: RTL
=======================

Name: redmule_cfg_master

Overview:
- Initiator for the RedMulE 64-bit peripheral configuration port.
- Used by the cluster-side offload sequencer and by test harnesses to program a job without a core.
- Sequence: acquire a job slot, write N IO registers from a word stream, write TRIGGER, wait for the end-of-job event, then report done.
- Drives 32-bit register accesses onto the 64-bit bus using lane select via byte enables.

Parameters:
- ID_WIDTH, 8, width of the request/response id field.
- BASE_ADDR, 32'h0000_0000, base address of the accelerator register map.
- IO_REG_OFFS, 32'h40, offset of the first job-dependent IO register.
- MAX_RETRY, 16, acquire attempts before error.
- RETRY_GAP, 4, idle cycles between acquire attempts (≥1).
- REQ_ID, 8'h01, constant id driven on id_o.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- clear_i  in  1  synchronous soft clear
- start_i  in  1  start pulse; sampled only in IDLE
- n_regs_i  in  6  number of IO register words to write; sampled with start_i
- cfg_valid_i  in  1  config word valid
- cfg_ready_o  out  1  config word accepted (valid&ready)
- cfg_data_i  in  32  config word
- req_o  out  1  bus request
- add_o  out  32  byte address
- wen_o  out  1  1 = read, 0 = write
- be_o  out  8  byte enables
- data_o  out  64  write data
- id_o  out  ID_WIDTH  request id
- gnt_i  in  1  grant
- r_data_i  in  64  read data
- r_valid_i  in  1  response valid
- r_id_i  in  ID_WIDTH  response id
- evt_i  in  1  end-of-job event from the accelerator (core-0 event bit)
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle job-complete pulse
- job_id_o  out  8  id returned by ACQUIRE; valid from the first write until the next start
- error_o  out  1  sticky acquire failure; cleared by start_i or clear_i

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i.
- Reset values are 0 for all outputs, all counters, and job_id_o; state resets to IDLE.

Register map (BASE_ADDR-relative):
- TRIGGER 0x00
- ACQUIRE 0x04
- IO register i at IO_REG_OFFS + 4*i

Bus rules:
- At most one outstanding transaction.
- req_o, add_o, wen_o, be_o and data_o are held stable from req rise until the cycle gnt_i is high; req_o drops the cycle after gnt_i.
- A write completes at gnt_i.
- A read completes at r_valid_i with r_id_i == REQ_ID; responses with other ids are ignored.
- Lane select: add_o[2]=0 gives be_o=8'h0F and data in data_o[31:0], upper half zero. add_o[2]=1 gives be_o=8'hF0 and data in data_o[63:32], lower half zero.
- Read data is always taken from r_data_i[31:0].

FSM:
- IDLE: start_i → ACQ_REQ. Latch n_regs_i, clear the retry count, clear error_o.
- ACQ_REQ: read ACQUIRE; on gnt → ACQ_RSP.
- ACQ_RSP: on r_valid, inspect r_data_i[31:0].
  - Bit 31 = 0: job_id_o ← r_data_i[7:0]. Go to WR_REG if the latched n_regs > 0, else TRIG.
  - Bit 31 = 1 (busy): increment the retry count. If the count reaches MAX_RETRY, set error_o and go to IDLE with no done_o; otherwise go to ACQ_WAIT.
- ACQ_WAIT: count RETRY_GAP cycles → ACQ_REQ.
- WR_REG: cfg_ready_o=1 only while req_o is low and no word is held.
  - An accepted word is captured and written to IO register index = word count.
  - On gnt, increment the word count. When count == latched n_regs → TRIG.
  - Stalls indefinitely while cfg_valid_i is low.
- TRIG: write 32'h0 to TRIGGER; on gnt → WAIT_EVT.
- WAIT_EVT: evt_i → DONE. evt_i in any other state is ignored.
- DONE: done_o=1 for one cycle → IDLE.

Counters and data:
- Word count is 6 bits; no wrap, since n_regs ≤ 63.
- Retry count is ⌈log2(MAX_RETRY+1)⌉ bits.
- start_i outside IDLE is ignored.

Clear and reset mid-operation:
- clear_i forces IDLE next cycle, drops req_o, clears counters and error_o, and keeps job_id_o.
- If a read was granted but not yet answered, a drain flag is set. The next matching r_valid_i is discarded and clears the flag. start_i is ignored while the flag is set.
- clear_i and gnt_i in the same cycle: clear wins; the granted write is considered issued and is not retried.

Test Plan:
- Single job: ACQUIRE returns 0x0000_0003, n_regs=3, words A,B,C. Expect writes to 0x40 (be 0F), 0x44 (be F0, data in [63:32]), 0x48 (be 0F), then TRIGGER 0x00 with data 0. After evt_i, one done_o pulse; job_id_o=3.
- Acquire busy: slave returns 0xFFFF_FFFF twice then 0x1. Expect 3 ACQUIRE reads, each retry separated by ≥RETRY_GAP=4 idle cycles, then normal progress.
- Acquire exhaustion: MAX_RETRY=16 and slave always returns negative. Expect exactly 16 reads, error_o=1, busy_o=0, no done_o, no writes issued.
- Backpressure: gnt_i delayed 5 cycles per request and cfg_valid_i toggled randomly. Request fields stay stable until gnt, no word is lost or duplicated, and order matches input.
- Clear during ACQ_RSP after grant: a late r_valid arrives 3 cycles after clear. Verify it is discarded, a start_i in between is ignored, and the next job completes normally.
- n_regs=0: expect ACQUIRE then TRIGGER only, cfg_ready_o never high, and done_o after evt_i.

Source files
------------

// File: rtl/redmule_cfg_master_if.sv
// rtl/redmule_cfg_master_if.sv - RedMulE 64-bit peripheral configuration bus
interface redmule_cfg_master_if #(
  parameter int unsigned ID_WIDTH = 8
);
  logic                req_o;
  logic [31:0]         add_o;
  logic                wen_o;
  logic [7:0]          be_o;
  logic [63:0]         data_o;
  logic [ID_WIDTH-1:0] id_o;
  logic                gnt_i;
  logic [63:0]         r_data_i;
  logic                r_valid_i;
  logic [ID_WIDTH-1:0] r_id_i;

  modport master (
    output req_o, add_o, wen_o, be_o, data_o, id_o,
    input  gnt_i, r_data_i, r_valid_i, r_id_i
  );

  modport slave (
    input  req_o, add_o, wen_o, be_o, data_o, id_o,
    output gnt_i, r_data_i, r_valid_i, r_id_i
  );
endinterface

// File: rtl/redmule_cfg_master.sv
// rtl/redmule_cfg_master.sv - RedMulE job programmer: acquire, write IO regs, trigger, wait end-of-job
module redmule_cfg_master #(
  parameter int unsigned         ID_WIDTH    = 8,
  parameter logic [31:0]         BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0]         IO_REG_OFFS = 32'h40,
  parameter int unsigned         MAX_RETRY   = 16,
  parameter int unsigned         RETRY_GAP   = 4,
  parameter logic [ID_WIDTH-1:0] REQ_ID      = 8'h01
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic [5:0]                  n_regs_i,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [31:0]                 cfg_data_i,
  redmule_cfg_master_if.master        bus,
  input  logic                        evt_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [7:0]                  job_id_o,
  output logic                        error_o
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam logic [RW-1:0] MAX_CNT   = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GAP_LAST  = GW'(RETRY_GAP - 1);
  localparam logic [31:0]   TRIG_ADDR = BASE_ADDR;
  localparam logic [31:0]   ACQ_ADDR  = BASE_ADDR + 32'h4;
  localparam logic [31:0]   IO_BASE   = BASE_ADDR + IO_REG_OFFS;

  typedef enum logic [2:0] {
    IDLE, ACQ_REQ, ACQ_RSP, ACQ_WAIT, WR_REG, TRIG, WAIT_EVT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    n_regs_q, n_regs_d;
  logic [5:0]    word_cnt_q, word_cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    job_id_q, job_id_d;
  logic          error_q, error_d;
  logic          drain_q, drain_d;
  logic          req_q, req_d;
  logic [31:0]   add_q, add_d;
  logic          wen_q, wen_d;
  logic [31:0]   word_q, word_d;

  logic          launch;
  logic [31:0]   launch_addr;
  logic          launch_wen;
  logic [31:0]   launch_word;
  logic          rsp_hit;
  logic          unused_rdata;

  assign rsp_hit      = bus.r_valid_i && (bus.r_id_i == REQ_ID);
  assign unused_rdata = ^{bus.r_data_i[63:32], bus.r_data_i[30:8]};

  always_comb begin
    state_d     = state_q;
    n_regs_d    = n_regs_q;
    word_cnt_d  = word_cnt_q;
    retry_d     = retry_q;
    gap_d       = gap_q;
    job_id_d    = job_id_q;
    error_d     = error_q;
    drain_d     = drain_q;
    req_d       = req_q;
    add_d       = add_q;
    wen_d       = wen_q;
    word_d      = word_q;
    launch      = 1'b0;
    launch_addr = '0;
    launch_wen  = 1'b0;
    launch_word = '0;
    cfg_ready_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !drain_q) begin
          state_d    = ACQ_REQ;
          n_regs_d   = n_regs_i;
          word_cnt_d = '0;
          retry_d    = '0;
          error_d    = 1'b0;
        end
      end
      ACQ_REQ: begin
        if (!req_q) begin
          launch      = 1'b1;
          launch_addr = ACQ_ADDR;
          launch_wen  = 1'b1;
        end else if (bus.gnt_i) begin
          req_d   = 1'b0;
          state_d = ACQ_RSP;
        end
      end
      ACQ_RSP: begin
        if (rsp_hit) begin
          if (!bus.r_data_i[31]) begin
            job_id_d = bus.r_data_i[7:0];
            state_d  = (n_regs_q != 6'd0) ? WR_REG : TRIG;
          end else begin
            retry_d = retry_q + 1'b1;
            if (retry_d == MAX_CNT) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else begin
              gap_d   = '0;
              state_d = ACQ_WAIT;
            end
          end
        end
      end
      ACQ_WAIT: begin
        if (gap_q == GAP_LAST) state_d = ACQ_REQ;
        else                   gap_d   = gap_q + 1'b1;
      end
      WR_REG: begin
        // A word is only taken while the bus is idle, so the in-flight request is the held word.
        if (!req_q) begin
          cfg_ready_o = !clear_i;
          if (cfg_valid_i && !clear_i) begin
            launch      = 1'b1;
            launch_addr = IO_BASE + {24'b0, word_cnt_q, 2'b00};
            launch_word = cfg_data_i;
          end
        end else if (bus.gnt_i) begin
          req_d      = 1'b0;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_d == n_regs_q) state_d = TRIG;
        end
      end
      TRIG: begin
        if (!req_q) begin
          launch      = 1'b1;
          launch_addr = TRIG_ADDR;
        end else if (bus.gnt_i) begin
          req_d   = 1'b0;
          state_d = WAIT_EVT;
        end
      end
      WAIT_EVT: begin
        if (evt_i) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch) begin
      req_d  = 1'b1;
      add_d  = launch_addr;
      wen_d  = launch_wen;
      word_d = launch_word;
    end

    if (drain_q && rsp_hit) drain_d = 1'b0;

    // An abandoned granted read still owes a response; remember to swallow it.
    if (clear_i) begin
      state_d    = IDLE;
      req_d      = 1'b0;
      word_cnt_d = '0;
      retry_d    = '0;
      gap_d      = '0;
      error_d    = 1'b0;
      if ((state_q == ACQ_RSP && !rsp_hit) || (state_q == ACQ_REQ && req_q && bus.gnt_i))
        drain_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      n_regs_q   <= '0;
      word_cnt_q <= '0;
      retry_q    <= '0;
      gap_q      <= '0;
      job_id_q   <= '0;
      error_q    <= 1'b0;
      drain_q    <= 1'b0;
      req_q      <= 1'b0;
      add_q      <= '0;
      wen_q      <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_regs_q   <= n_regs_d;
      word_cnt_q <= word_cnt_d;
      retry_q    <= retry_d;
      gap_q      <= gap_d;
      job_id_q   <= job_id_d;
      error_q    <= error_d;
      drain_q    <= drain_d;
      req_q      <= req_d;
      add_q      <= add_d;
      wen_q      <= wen_d;
      word_q     <= word_d;
    end
  end

  assign bus.req_o  = req_q;
  assign bus.add_o  = add_q;
  assign bus.wen_o  = wen_q;
  assign bus.be_o   = !req_q ? 8'h00 : (add_q[2] ? 8'hF0 : 8'h0F);
  assign bus.data_o = !req_q ? 64'h0 : (add_q[2] ? {word_q, 32'h0} : {32'h0, word_q});
  assign bus.id_o   = req_q ? REQ_ID : '0;

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign job_id_o = job_id_q;
  assign error_o  = error_q;

endmodule
